// File: rtl/crc_cmd_seq_if.sv
// Byte-stream and register-block signals of the CRC command sequencer.
// master: the sequencer itself; slave: the receiver/transmitter/block side.
interface crc_cmd_seq_if;
    logic [7:0]  rx_dat;
    logic        ce_rx;
    logic        tx_rdy;
    logic [7:0]  my_dat;
    logic [7:0]  tx_dat;
    logic        ce_tx;
    logic [7:0]  com;
    logic [15:0] wr_adr;
    logic [15:0] rd_adr;
    logic [7:0]  wr_dat;
    logic        ce_wr_dat;
    logic        busy;
    logic        rx_ovf;

    modport master (
        input  rx_dat, ce_rx, tx_rdy, my_dat,
        output tx_dat, ce_tx, com, wr_adr, rd_adr, wr_dat, ce_wr_dat, busy, rx_ovf
    );

    modport slave (
        output rx_dat, ce_rx, tx_rdy, my_dat,
        input  tx_dat, ce_tx, com, wr_adr, rd_adr, wr_dat, ce_wr_dat, busy, rx_ovf
    );
endinterface

// File: rtl/crc_cmd_seq.sv
// CRC-8 framed command sequencer: parses request frames, drives block writes/reads, answers.
// Define CRC_CHECK_EN to compare the request CRC byte (mismatch -> status E1, no execution).
module crc_cmd_seq #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TOUT    = 50000
) (
    input logic           clk,
    input logic           rst,
    crc_cmd_seq_if.master bus_io
);
    localparam int unsigned IdxW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LatW     = $clog2(RD_LAT + 2);
    localparam int unsigned ToutW    = $clog2(TOUT + 1);
    localparam logic [7:0]       MaxLen   = 8'(MAX_LEN);
    localparam logic [LatW-1:0]  LatLast  = LatW'(RD_LAT);
    localparam logic [ToutW-1:0] ToutLast = ToutW'(TOUT - 1);
    localparam logic [7:0] OpWr = 8'h57, OpRd = 8'h52;
    localparam logic [7:0] StatOk = 8'hA5, StatCrc = 8'hE1, StatLen = 8'hE2;

    typedef enum logic [3:0] {
        StIdle, StHCom, StHAdrH, StHAdrL, StHLen, StData, StCrc, StCheck,
        StExecWr, StExecRd, StTxStat, StTxDat, StTxCrc
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       com_q, com_d, len_q, len_d, cnt_q, cnt_d;
    logic [7:0]       crc_q, crc_d, status_q, status_d;
    logic [15:0]      adr_q, adr_d;
    logic             is_wr_q, is_wr_d, ph_q, ph_d, gap_q, gap_d, rx_ovf_q, rx_ovf_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic [ToutW-1:0] tout_q, tout_d;
    logic [7:0]       buf_q [MAX_LEN];
    logic             buf_we;
    logic [7:0]       buf_wdat;
    logic [IdxW-1:0]  idx;
    logic             in_frame, busy_w, tx_fire, len_bad;
    logic [15:0]      cur_adr;

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] dat);
        logic [7:0] c;
        c = crc ^ dat;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign idx      = cnt_q[IdxW-1:0];
    assign cur_adr  = adr_q + {8'h00, cnt_q};
    assign in_frame = state_q inside {StHCom, StHAdrH, StHAdrL, StHLen, StData, StCrc};
    assign busy_w   = state_q inside {StCheck, StExecWr, StExecRd, StTxStat, StTxDat, StTxCrc};
    assign tx_fire  = bus_io.tx_rdy & ~gap_q;
    assign len_bad  = (len_q == 8'd0) || (len_q > MaxLen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            com_q    <= 8'h00;
            len_q    <= 8'h00;
            cnt_q    <= 8'h00;
            crc_q    <= 8'h00;
            status_q <= 8'h00;
            adr_q    <= 16'h0000;
            is_wr_q  <= 1'b0;
            ph_q     <= 1'b0;
            gap_q    <= 1'b0;
            rx_ovf_q <= 1'b0;
            lat_q    <= '0;
            tout_q   <= '0;
        end else begin
            state_q  <= state_d;
            com_q    <= com_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            status_q <= status_d;
            adr_q    <= adr_d;
            is_wr_q  <= is_wr_d;
            ph_q     <= ph_d;
            gap_q    <= gap_d;
            rx_ovf_q <= rx_ovf_d;
            lat_q    <= lat_d;
            tout_q   <= tout_d;
        end
    end

    // Payload storage is not reset: a reset must not disturb anything but control state.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx] <= buf_wdat;
    end

    always_comb begin
        state_d  = state_q;
        com_d    = com_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        status_d = status_q;
        adr_d    = adr_q;
        is_wr_d  = is_wr_q;
        ph_d     = ph_q;
        gap_d    = 1'b0;
        lat_d    = lat_q;
        rx_ovf_d = rx_ovf_q | (bus_io.ce_rx & busy_w);
        tout_d   = (in_frame && !bus_io.ce_rx) ? tout_q + 1'b1 : '0;
        buf_we   = 1'b0;
        buf_wdat = bus_io.rx_dat;
        unique case (state_q)
            StIdle: if (bus_io.ce_rx && (bus_io.rx_dat == OpWr || bus_io.rx_dat == OpRd)) begin
                is_wr_d  = (bus_io.rx_dat == OpWr);
                crc_d    = crc8(8'h00, bus_io.rx_dat);
                rx_ovf_d = 1'b0;
                state_d  = StHCom;
            end
            StHCom: if (bus_io.ce_rx) begin
                com_d   = bus_io.rx_dat;
                crc_d   = crc8(crc_q, bus_io.rx_dat);
                state_d = StHAdrH;
            end
            StHAdrH: if (bus_io.ce_rx) begin
                adr_d[15:8] = bus_io.rx_dat;
                crc_d       = crc8(crc_q, bus_io.rx_dat);
                state_d     = StHAdrL;
            end
            StHAdrL: if (bus_io.ce_rx) begin
                adr_d[7:0] = bus_io.rx_dat;
                crc_d      = crc8(crc_q, bus_io.rx_dat);
                state_d    = StHLen;
            end
            StHLen: if (bus_io.ce_rx) begin
                len_d   = bus_io.rx_dat;
                cnt_d   = 8'h00;
                crc_d   = crc8(crc_q, bus_io.rx_dat);
                state_d = (is_wr_q && bus_io.rx_dat != 8'h00) ? StData : StCrc;
            end
            StData: if (bus_io.ce_rx) begin
                // Oversized payloads are counted through but only the first MAX_LEN are kept.
                buf_we  = (cnt_q < MaxLen);
                crc_d   = crc8(crc_q, bus_io.rx_dat);
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) state_d = StCrc;
            end
            StCrc: if (bus_io.ce_rx) begin
`ifdef CRC_CHECK_EN
                status_d = len_bad ? StatLen : (bus_io.rx_dat != crc_q) ? StatCrc : StatOk;
`else
                status_d = len_bad ? StatLen : StatOk;
`endif
                state_d  = StCheck;
            end
            StCheck: begin
                cnt_d = 8'h00;
                ph_d  = 1'b0;
                lat_d = '0;
                if (status_q != StatOk) state_d = StTxStat;
                else                    state_d = is_wr_q ? StExecWr : StExecRd;
            end
            StExecWr: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        cnt_d   = 8'h00;
                        state_d = StTxStat;
                    end
                end
            end
            StExecRd: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LatLast) begin
                    lat_d    = '0;
                    buf_we   = 1'b1;
                    buf_wdat = bus_io.my_dat;
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        cnt_d   = 8'h00;
                        state_d = StTxStat;
                    end
                end
            end
            StTxStat: if (tx_fire) begin
                gap_d   = 1'b1;
                crc_d   = crc8(8'h00, status_q);
                cnt_d   = 8'h00;
                state_d = (!is_wr_q && status_q == StatOk) ? StTxDat : StTxCrc;
            end
            StTxDat: if (tx_fire) begin
                gap_d = 1'b1;
                crc_d = crc8(crc_q, buf_q[idx]);
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) state_d = StTxCrc;
            end
            StTxCrc: if (tx_fire) begin
                gap_d   = 1'b1;
                crc_d   = 8'h00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (in_frame && !bus_io.ce_rx && tout_q == ToutLast) begin
            state_d = StIdle;
            crc_d   = 8'h00;
        end
    end

    always_comb begin
        bus_io.com       = 8'hFF;
        bus_io.wr_adr    = 16'hFFFF;
        bus_io.rd_adr    = 16'hFFFF;
        bus_io.wr_dat    = 8'h00;
        bus_io.ce_wr_dat = 1'b0;
        bus_io.tx_dat    = 8'h00;
        bus_io.ce_tx     = 1'b0;
        bus_io.busy      = busy_w;
        bus_io.rx_ovf    = rx_ovf_q;
        unique case (state_q)
            StExecWr: begin
                bus_io.com = com_q;
                if (!ph_q) begin
                    bus_io.ce_wr_dat = 1'b1;
                    bus_io.wr_adr    = cur_adr;
                    bus_io.wr_dat    = buf_q[idx];
                end
            end
            StExecRd: begin
                bus_io.com    = com_q;
                bus_io.rd_adr = cur_adr;
            end
            StTxStat: begin
                bus_io.tx_dat = status_q;
                bus_io.ce_tx  = tx_fire;
            end
            StTxDat: begin
                bus_io.tx_dat = buf_q[idx];
                bus_io.ce_tx  = tx_fire;
            end
            StTxCrc: begin
                bus_io.tx_dat = crc_q;
                bus_io.ce_tx  = tx_fire;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_crc_cmd_seq.sv
// Directed bench for crc_cmd_seq: write/read frames, CRC and length errors, timeout,
// address wrap, receive overflow under transmit back-pressure and reset mid-write.
module tb_crc_cmd_seq;
    localparam int unsigned ToutCyc = 300;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    crc_cmd_seq_if bus ();

    crc_cmd_seq #(.MAX_LEN(16), .RD_LAT(2), .TOUT(ToutCyc)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] wr_q[$];
    logic [15:0] rd_q[$];
    logic        prev_wr = 1'b0, prev_tx = 1'b0;
    logic [7:0]  d1 = 8'h00, d2 = 8'h00;

    // Block model: RD_LAT=2 register stages between rd_adr and my_dat.
    function automatic logic [7:0] blk(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h12;
            16'h1001: return 8'h34;
            16'h1002: return 8'h56;
            16'h1003: return 8'h78;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        d1 <= blk(bus.rd_adr);
        d2 <= d1;
    end
    assign bus.my_dat = d2;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ce_tx) tx_q.push_back(bus.tx_dat);
            if (bus.ce_wr_dat) wr_q.push_back({bus.com, bus.wr_adr, bus.wr_dat});
            if (bus.rd_adr != 16'hFFFF && (rd_q.size() == 0 || rd_q[$] != bus.rd_adr))
                rd_q.push_back(bus.rd_adr);
            if ((bus.ce_wr_dat && prev_wr) || (!bus.ce_wr_dat && bus.wr_adr != 16'hFFFF) ||
                (bus.ce_tx && (!bus.tx_rdy || prev_tx)))
                viol <= viol + 1;
            prev_wr <= bus.ce_wr_dat;
            prev_tx <= bus.ce_tx;
        end
    end

    function automatic logic [7:0] crc8(input bq_t f);
        logic [7:0] c = 8'h00;
        foreach (f[k]) begin
            c = c ^ f[k];
            for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_dat = b;
        bus.ce_rx  = 1'b1;
        @(posedge clk); #1;
        bus.ce_rx  = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input bit corrupt);
        logic [7:0] c;
        c = crc8(f) ^ {7'd0, corrupt};
        foreach (f[k]) send_byte(f[k]);
        send_byte(c);
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int i = 0; i < 3000 && tx_q.size() < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk({tag, "_txcnt"}, tx_q.size(), n);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    task automatic chk_tx(input bq_t exp, input string tag);
        foreach (exp[k]) if (k < tx_q.size()) chk($sformatf("%s_tx%0d", tag, k), tx_q[k], exp[k]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_com"}, bus.com, 8'hFF);
        chk({tag, "_wradr"}, bus.wr_adr, 16'hFFFF);
        chk({tag, "_rdadr"}, bus.rd_adr, 16'hFFFF);
        chk({tag, "_wrdat"}, bus.wr_dat, 8'h00);
        chk({tag, "_cewr"}, bus.ce_wr_dat, 1'b0);
        chk({tag, "_cetx"}, bus.ce_tx, 1'b0);
        chk({tag, "_txdat"}, bus.tx_dat, 8'h00);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_ovf"}, bus.rx_ovf, 1'b0);
    endtask

    task automatic clr;
        tx_q.delete();
        wr_q.delete();
        rd_q.delete();
    endtask

    initial begin
        bq_t fr, rd_exp;
        bus.rx_dat = 8'h00;
        bus.ce_rx  = 1'b0;
        bus.tx_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic write: two strobes, response A5 72.
        clr();
        fr = '{8'h57, 8'h81, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB};
        send_frame(fr, 1'b0);
        wait_tx(2, "wr");
        chk("wr_n", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("wr_0", wr_q[0], 32'h81_1000_AA);
            chk("wr_1", wr_q[1], 32'h81_1001_BB);
        end
        chk_tx('{8'hA5, 8'h72}, "wr");

        // Read of four bytes; response carries block data and running CRC.
        clr();
        fr = '{8'h52, 8'h80, 8'h10, 8'h00, 8'h04};
        send_frame(fr, 1'b0);
        rd_exp = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78};
        rd_exp.push_back(crc8(rd_exp));
        wait_tx(6, "rd");
        chk_tx(rd_exp, "rd");
        chk("rd_n", rd_q.size(), 4);
        foreach (rd_q[k]) chk($sformatf("rd_adr%0d", k), rd_q[k], 16'h1000 + 16'(k));
        chk("rd_wr_n", wr_q.size(), 0);
        chk("rd_adr_end", bus.rd_adr, 16'hFFFF);

        // Corrupted request CRC.
        clr();
        fr = '{8'h57, 8'h81, 8'h20, 8'h00, 8'h01, 8'hCC};
        send_frame(fr, 1'b1);
        wait_tx(2, "bad");
`ifdef CRC_CHECK_EN
        chk("bad_wr_n", wr_q.size(), 0);
        chk_tx('{8'hE1, 8'hA9}, "bad");
`else
        chk("bad_wr_n", wr_q.size(), 1);
        chk_tx('{8'hA5, 8'h72}, "bad");
`endif

        // Length errors: LEN=0 and LEN=17.
        clr();
        fr = '{8'h57, 8'h81, 8'h10, 8'h00, 8'h00};
        send_frame(fr, 1'b0);
        wait_tx(2, "len0");
        chk_tx('{8'hE2, 8'hA0}, "len0");
        clr();
        fr = '{8'h57, 8'h81, 8'h10, 8'h00, 8'h11};
        for (int i = 0; i < 17; i++) fr.push_back(8'(i));
        send_frame(fr, 1'b0);
        wait_tx(2, "len17");
        chk_tx('{8'hE2, 8'hA0}, "len17");
        chk("len_wr_n", wr_q.size(), 0);

        // Stall mid-header past the timeout, then a wrapping write must parse cleanly.
        clr();
        send_byte(8'h57);
        send_byte(8'h81);
        send_byte(8'h30);
        repeat (ToutCyc + 1) @(negedge clk);
        chk("tout_tx", tx_q.size(), 0);
        chk("tout_busy", bus.busy, 1'b0);
        fr = '{8'h57, 8'h81, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22};
        send_frame(fr, 1'b0);
        wait_tx(2, "wrap");
        chk("wrap_n", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("wrap_0", wr_q[0], 32'h81_FFFF_11);
            chk("wrap_1", wr_q[1], 32'h81_0000_22);
        end
        chk_tx('{8'hA5, 8'h72}, "wrap");

        // Back-pressure during data phase plus a stray byte while busy.
        clr();
        fr = '{8'h52, 8'h80, 8'h10, 8'h00, 8'h04};
        send_frame(fr, 1'b0);
        for (int i = 0; i < 200 && tx_q.size() < 1; i++) @(negedge clk);
        bus.tx_rdy = 1'b0;
        chk("ovf_stat", tx_q.size(), 1);
        send_byte(8'h57);
        repeat (100) @(negedge clk);
        chk("ovf_flag", bus.rx_ovf, 1'b1);
        chk("ovf_hold", tx_q.size(), 1);
        chk("ovf_busy", bus.busy, 1'b1);
        bus.tx_rdy = 1'b1;
        wait_tx(6, "ovf");
        chk_tx(rd_exp, "ovf");

        // Reset in the middle of a write burst.
        clr();
        fr = '{8'h57, 8'h81, 8'h40, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(fr, 1'b0);
        chk("ovf_clr", bus.rx_ovf, 1'b0);
        for (int i = 0; i < 200 && wr_q.size() < 1; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_cewr", bus.ce_wr_dat, 1'b0);
        @(negedge clk);
        chk_idle("rstw");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw_n", wr_q.size(), 1);
        if (wr_q.size() == 1) chk("rstw_0", wr_q[0], 32'h81_4000_01);
        chk("rstw_tx", tx_q.size(), 0);

        clr();
        fr = '{8'h52, 8'h80, 8'h10, 8'h03, 8'h01};
        send_frame(fr, 1'b0);
        fr = '{8'hA5, 8'h78};
        fr.push_back(crc8(fr));
        wait_tx(3, "post");
        chk_tx(fr, "post");
        chk("protocol_viol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
